regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Issue/writeback controller for the 32x32 register file in the pipelined RV32 core.
- Tracks in-flight destination registers with per-register pending counters and raises a decode stall on RAW/WAW-overflow hazards.
- Owns the register file's single write port and arbitrates it between pipeline writeback (priority) and a debug/loader write requester with a req/gnt handshake.

Parameters:
N, 32, data width (from defines.v).
NREG, 32, architectural register count; index width 5.
CNT_W, 2, pending-counter width; max in-flight writes per register = 2^CNT_W-1 = 3.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
id_valid  input  1  decode holds a valid instruction.
id_rs1 / id_rs2  input  5  source indices.
id_rs1_used / id_rs2_used  input  1  source actually read.
id_rd  input  5  destination index.
id_rd_we  input  1  instruction writes rd.
id_stall  output  1  hold decode this cycle (combinational).
kill_valid  input  1  one squashed in-flight instruction is retired without writing.
kill_rd  input  5  its destination (issued with rd_we=1).
wb_valid  input  1  writeback commits this cycle.
wb_rd  input  5  writeback destination.
wb_data  input  N  writeback value.
dbg_req  input  1  debug write request; held until granted.
dbg_rd  input  5  debug destination.
dbg_data  input  N  debug value.
dbg_gnt  output  1  debug write performed this cycle (combinational).
rf_we  output  1  register-file write enable.
rf_waddr  output  5  register-file write index.
rf_wdata  output  N  register-file write data.
busy  output  NREG  bit i = pending counter i nonzero.
err_underflow  output  1  sticky: wb/kill hit a zero counter.

Behaviour:
- State: cnt[1..31] (CNT_W bits each), err_underflow. cnt[0] is hard-wired 0; busy[0]=0.
- Reset (synchronous, rst high at posedge): all cnt=0, err_underflow=0. Comb outputs then: busy=0, id_stall=0, rf_we=wb_valid&&wb_rd!=0 (reset does not block the write port).
- Hazard: raw1 = id_rs1_used && id_rs1!=0 && cnt[id_rs1]!=0; raw2 likewise. waw = id_rd_we && id_rd!=0 && cnt[id_rd]==max.
- id_stall = id_valid && (raw1||raw2||waw). No same-cycle bypass: a register written by wb this cycle still stalls this cycle; the value is readable the next cycle.
- accept = id_valid && !id_stall && id_rd_we && id_rd!=0 -> inc[id_rd].
- wb_valid && wb_rd!=0 -> dec[wb_rd]. kill_valid && kill_rd!=0 -> dec[kill_rd].
- Per register, next cnt = cnt + inc - dec_wb - dec_kill. All three on one register are legal: net -1.
- If decrements exceed cnt+inc: cnt clamps to 0 and err_underflow sets. It stays set until rst.
- Increment never overflows because waw stalls at max.
- Write port, combinational:
  - wb_valid && wb_rd!=0: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data, dbg_gnt=0.
  - else dbg_gnt = dbg_req && (dbg_rd==0 || (cnt[dbg_rd]==0 && !(accept && id_rd==dbg_rd))). When granted with dbg_rd!=0: rf_we=1, rf_waddr=dbg_rd, rf_wdata=dbg_data.
  - Granting dbg_rd=0 only completes the handshake; rf_we=0.
  - Otherwise rf_we=0, rf_waddr=0, rf_wdata=0.
- Debug handshake: requester holds dbg_req/dbg_rd/dbg_data stable until dbg_gnt=1. It may drop dbg_req the cycle after grant. Debug writes never change cnt.
- wb_valid with wb_rd=0: no write, no count change, no underflow error, and the port is free for debug.

Decomposition:
- Shared package/defines: N, NREG, REG_IDX_W=5, CNT_W.
- One natural sub-module: sb_counter, a single saturating up/down pending counter with inc, dec_a, dec_b, underflow flag. Instantiate 31 times via generate.
- Hazard compare and write-port mux stay in the top module.

Test Plan:
- Reset: rst high 1 cycle with wb_valid=1, wb_rd=5 -> busy=0, err_underflow=0, id_stall=0 after reset; rf_we=1, rf_waddr=5 during reset.
- RAW: issue rd=5 (rd_we=1), next cycle id_rs1=5 used -> id_stall=1. wb_rd=5 at cycle 3 -> stall still 1 that cycle, 0 at cycle 4; busy[5] clears at cycle 4.
- WAW saturation: three accepted issues to rd=7 -> cnt=3. Fourth id_rd=7 -> id_stall=1. One wb_rd=7 -> fourth accepted next cycle, cnt returns to 3.
- Simultaneous: cnt[9]=1, same cycle accept rd=9 + wb_rd=9 + kill_rd=9 -> cnt[9]=0, err_underflow=0.
- Arbitration: dbg_req rd=3 with wb_valid rd=4 -> dbg_gnt=0, rf_waddr=4. Next cycle wb idle, cnt[3]=0 -> dbg_gnt=1, rf_waddr=3, rf_wdata=dbg_data. With cnt[3]=1 -> dbg_gnt held 0.
- Underflow/x0: wb_rd=12 with cnt[12]=0 -> err_underflow=1 persists. wb_rd=0 -> rf_we=0, no error. id_rd=0 issues never stall or set busy.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths and types for the register-file scoreboard slice.
// Counter width bounds how many writes to one register may be in flight at once.
package regfile_scoreboard_pkg;
    localparam int N         = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [N-1:0]         data_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    localparam cnt_t CNT_MAX = '1;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode, kill, writeback, debug and register-file port bundle of the scoreboard.
// master = pipeline/debug side driving requests, slave = the scoreboard.
interface regfile_scoreboard_if;
    import regfile_scoreboard_pkg::*;

    logic              id_valid;
    reg_idx_t          id_rs1;
    reg_idx_t          id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    reg_idx_t          id_rd;
    logic              id_rd_we;
    logic              id_stall;
    logic              kill_valid;
    reg_idx_t          kill_rd;
    logic              wb_valid;
    reg_idx_t          wb_rd;
    data_t             wb_data;
    logic              dbg_req;
    reg_idx_t          dbg_rd;
    data_t             dbg_data;
    logic              dbg_gnt;
    logic              rf_we;
    reg_idx_t          rf_waddr;
    data_t             rf_wdata;
    logic [NREG-1:0]   busy;
    logic              err_underflow;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
        output kill_valid, kill_rd, wb_valid, wb_rd, wb_data, dbg_req, dbg_rd, dbg_data,
        input  id_stall, dbg_gnt, rf_we, rf_waddr, rf_wdata, busy, err_underflow
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
        input  kill_valid, kill_rd, wb_valid, wb_rd, wb_data, dbg_req, dbg_rd, dbg_data,
        output id_stall, dbg_gnt, rf_we, rf_waddr, rf_wdata, busy, err_underflow
    );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// One register's pending-write counter: +inc, -dec_a, -dec_b in the same cycle.
// Clamps at zero and flags the underflow combinationally for the owner to latch.
module sb_counter
    import regfile_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_a_i,
    input  logic dec_b_i,
    output cnt_t cnt_o,
    output logic underflow_o
);
    cnt_t             cnt_q;
    cnt_t             cnt_d;
    logic [CNT_W:0]   up;
    logic [CNT_W:0]   down;

    // One extra bit so cnt+inc at max and the double decrement are both representable.
    always_comb begin
        up          = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc_i};
        down        = {{CNT_W{1'b0}}, dec_a_i} + {{CNT_W{1'b0}}, dec_b_i};
        underflow_o = (down > up);
        cnt_d       = underflow_o ? '0 : cnt_t'(up - down);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Issue/writeback scoreboard for the 32x32 register file: RAW/WAW-overflow decode stall,
// plus the single write port shared by writeback (priority) and a debug req/gnt writer.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    regfile_scoreboard_if.slave   bus
);
    cnt_t            cnt [NREG];
    logic [NREG-1:1] uf;
    logic            raw1, raw2, waw, stall, accept, wb_port;
    logic            gnt, we;
    reg_idx_t        waddr;
    data_t           wdata;
    logic            err_underflow_q, err_underflow_d;

    assign cnt[0]    = '0;
    assign bus.busy[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        sb_counter u_cnt (
            .clk         (clk),
            .rst         (rst),
            .inc_i       (accept && bus.id_rd == reg_idx_t'(i)),
            .dec_a_i     (bus.wb_valid && bus.wb_rd == reg_idx_t'(i)),
            .dec_b_i     (bus.kill_valid && bus.kill_rd == reg_idx_t'(i)),
            .cnt_o       (cnt[i]),
            .underflow_o (uf[i])
        );
        assign bus.busy[i] = |cnt[i];
    end

    always_comb begin
        raw1   = bus.id_rs1_used && bus.id_rs1 != '0 && cnt[bus.id_rs1] != '0;
        raw2   = bus.id_rs2_used && bus.id_rs2 != '0 && cnt[bus.id_rs2] != '0;
        waw    = bus.id_rd_we && bus.id_rd != '0 && cnt[bus.id_rd] == CNT_MAX;
        stall  = bus.id_valid && (raw1 || raw2 || waw);
        accept = bus.id_valid && !stall && bus.id_rd_we && bus.id_rd != '0;
    end

    // Debug may only write a register with nothing in flight, including an issue accepted now.
    always_comb begin
        wb_port = bus.wb_valid && bus.wb_rd != '0;
        gnt     = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        if (wb_port) begin
            we    = 1'b1;
            waddr = bus.wb_rd;
            wdata = bus.wb_data;
        end else begin
            gnt = bus.dbg_req && (bus.dbg_rd == '0 ||
                  (cnt[bus.dbg_rd] == '0 && !(accept && bus.id_rd == bus.dbg_rd)));
            if (gnt && bus.dbg_rd != '0) begin
                we    = 1'b1;
                waddr = bus.dbg_rd;
                wdata = bus.dbg_data;
            end
        end
    end

    assign err_underflow_d = err_underflow_q | (|uf);

    always_ff @(posedge clk) begin
        if (rst) err_underflow_q <= 1'b0;
        else     err_underflow_q <= err_underflow_d;
    end

    assign bus.id_stall      = stall;
    assign bus.dbg_gnt       = gnt;
    assign bus.rf_we         = we;
    assign bus.rf_waddr      = waddr;
    assign bus.rf_wdata      = wdata;
    assign bus.err_underflow = err_underflow_q;
endmodule
